// File: rtl/collatz_host_driver.sv
// collatz_host_driver: host-side initiator for the Collatz core byte protocol.
// Per job: load a BITS-wide start value one byte per cycle, pulse go, wait
// for the core to enter and leave COMPUTE, then read orbit length and
// path-record high bits back into the result registers.
// Optional build macro COLLATZ_HOST_CYCLE_COUNT_EN adds compute_cycles, the
// saturating count of WAIT_ENTER+WAIT_BUSY cycles of the last good job.
module collatz_host_driver #(
  parameter int BITS           = 144,
  parameter int OLEN_BITS      = 16,
  parameter int PLEN_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BITS-1:0]      value,
  output logic                 ready,
  output logic                 done,
  output logic                 timeout,
  output logic [OLEN_BITS-1:0] orbit_len,
  output logic [PLEN_BITS-1:0] path_record,
  output logic [7:0]           dut_ui_in,
  output logic [7:0]           dut_uio_in,
  input  logic [7:0]           dut_uo_out,
  input  logic [7:0]           dut_uio_out,
  input  logic [7:0]           dut_uio_oe
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
  ,
  output logic [31:0]          compute_cycles
`endif
);

  localparam int NBYTES = BITS / 8;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GO, S_WAIT_ENTER, S_WAIT_BUSY, S_READ
  } state_t;

  // Read address for result byte idx: 0x00, 0x01, 0x20, 0x21 (write=go=0).
  function automatic logic [7:0] rd_addr(input logic [1:0] idx);
    return {2'b00, idx[1], 4'b0000, idx[0]};
  endfunction

`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction
`endif

  state_t                 state_q, state_d;
  logic [4:0]             k_q, k_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [2:0]             rd_q, rd_d, rd_nxt;
  logic                   ready_q, ready_d, done_q, done_d, to_q, to_d;
  logic [OLEN_BITS-1:0]   olen_q, olen_d;
  logic [PLEN_BITS-1:0]   prec_q, prec_d;
  logic [7:0]             ui_q, ui_d, uio_q, uio_d;
  logic [BITS-1:0]        val_q, val_d;
  logic [7:0]             rb0_q, rb0_d, rb1_q, rb1_d, rb2_q, rb2_d;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
  logic [31:0]            cyc_q, cyc_d, ccyc_q, ccyc_d;
`endif

  // Only the COMPUTE flag is needed from the core's bidirectional pins.
  logic unused_pins;
  assign unused_pins = ^{dut_uio_out, dut_uio_oe[6:0]};

  // Next-state, next-output and datapath computation for the job sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rd_nxt  = rd_q + 3'd1;
    done_d  = 1'b0;
    to_d    = to_q;
    olen_d  = olen_q;
    prec_d  = prec_q;
    ui_d    = 8'h00;
    uio_d   = 8'h00;
    val_d   = val_q;
    rb0_d   = rb0_q;
    rb1_d   = rb1_q;
    rb2_d   = rb2_q;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
    cyc_d   = cyc_q;
    ccyc_d  = ccyc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d   = value >> 8;
          ui_d    = value[7:0];
          uio_d   = 8'h80;
          k_d     = 5'd0;
          to_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (k_q == 5'(NBYTES - 1)) begin
          uio_d   = 8'h40;
          state_d = S_GO;
        end else begin
          k_d   = k_q + 5'd1;
          ui_d  = val_q[7:0];
          val_d = val_q >> 8;
          uio_d = {3'b100, k_q + 5'd1};
        end
      end
      S_GO: begin
        cnt_d   = '0;
        state_d = S_WAIT_ENTER;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
        cyc_d   = 32'd0;
`endif
      end
      S_WAIT_ENTER: begin
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
        cyc_d = sat_inc(cyc_q);
`endif
        if (dut_uio_oe[7]) begin
          cnt_d   = '0;
          state_d = S_WAIT_BUSY;
        end else if (cnt_q == TW'(3)) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WAIT_BUSY: begin
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
        cyc_d = sat_inc(cyc_q);
`endif
        if (!dut_uio_oe[7]) begin
          rd_d    = 3'd0;
          uio_d   = rd_addr(2'd0);
          state_d = S_READ;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_READ: begin
        // Each address is held two cycles; the core's registered read data
        // is valid on the second edge, i.e. when rd_q is odd.
        rd_d  = rd_nxt;
        uio_d = rd_addr(rd_nxt[2:1]);
        if (rd_q == 3'd1) rb0_d = dut_uo_out;
        if (rd_q == 3'd3) rb1_d = dut_uo_out;
        if (rd_q == 3'd5) rb2_d = dut_uo_out;
        if (rd_q == 3'd7) begin
          olen_d  = OLEN_BITS'({rb1_q, rb0_q});
          prec_d  = PLEN_BITS'({dut_uo_out, rb2_q});
          done_d  = 1'b1;
          uio_d   = 8'h00;
          state_d = S_IDLE;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
          ccyc_d  = cyc_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Sequencer state and all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 5'd0;
      cnt_q   <= '0;
      rd_q    <= 3'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      olen_q  <= '0;
      prec_q  <= '0;
      ui_q    <= 8'h00;
      uio_q   <= 8'h00;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
      cyc_q   <= 32'd0;
      ccyc_q  <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      to_q    <= to_d;
      olen_q  <= olen_d;
      prec_q  <= prec_d;
      ui_q    <= ui_d;
      uio_q   <= uio_d;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
      cyc_q   <= cyc_d;
      ccyc_q  <= ccyc_d;
`endif
    end
  end

  // Load shift register and read-back byte holders; pure data, no reset.
  always_ff @(posedge clk) begin
    val_q <= val_d;
    rb0_q <= rb0_d;
    rb1_q <= rb1_d;
    rb2_q <= rb2_d;
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign orbit_len   = olen_q;
  assign path_record = prec_q;
  assign dut_ui_in   = ui_q;
  assign dut_uio_in  = uio_q;
`ifdef COLLATZ_HOST_CYCLE_COUNT_EN
  assign compute_cycles = ccyc_q;
`endif

endmodule
